// File: rtl/output_fifo_holder.sv
// Holding FIFO between the cipher core and the output mux; the head word stays on data_out until acknowledged.
// Optional OUTPUT_FIFO_DROP_OLDEST_EN: a push into a full FIFO overwrites the oldest word instead of being dropped.
module output_fifo_holder #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_pulse,
  input  logic              read_ack,
  input  logic              flush,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic              pop;
  logic              push;
  logic              ovf_evt;
  logic              drop_evt;
  logic              wr_en;

  assign full     = (count == CNT_W'(DEPTH));
  assign ready    = (count != '0);
  assign pop      = read_ack && ready;
  assign push     = data_in_pulse && (!full || pop);
  assign ovf_evt  = data_in_pulse && full && !pop;
`ifdef OUTPUT_FIFO_DROP_OLDEST_EN
  assign drop_evt = ovf_evt;
`else
  assign drop_evt = 1'b0;
`endif
  assign wr_en    = push || drop_evt;

  // Storage carries no reset; stale entries are never visible because data_out is masked by count.
  always_ff @(posedge clk) begin
    if (!flush && wr_en) mem[wptr] <= data_in;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_W'(1);
      // An overwrite retires the oldest word, so the read side moves with the write side.
      if (pop || drop_evt) rptr <= rptr + PTR_W'(1);
      if (push && !pop) count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (ovf_evt) overflow <= 1'b1;
    end
  end

  assign data_out = ready ? mem[rptr] : '0;

endmodule
